mem_burst_port_ctrl: RTL and testbench

Burst controller that drives one port of a dual-port memory bank. It accepts read or write burst commands on a valid/ready channel and streams write data in from one valid/ready channel. It issues one memory access per beat and returns read data on a valid/ready channel, with back-pressure absorbed by a 2-entry response buffer. Each memory port of a bank gets its own instance, so two masters can run bursts against the same bank in parallel.

---
 rtl/mem_burst_port_ctrl_if.sv | 48 ++++
 rtl/mem_burst_port_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_burst_port_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_port_ctrl_if
// Brief    : Command, write-data, read-data and memory-port bundle for one
//            burst controller instance.
// Revision : 1.0
// ============================================================================
interface mem_burst_port_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 3
);
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic             i_cmd_we;
  logic [ADDR-1:0]  i_cmd_addr;
  logic [ADDR-1:0]  i_cmd_len;
  logic             i_wdata_valid;
  logic             o_wdata_ready;
  logic [WIDTH-1:0] i_wdata;
  logic             o_rdata_valid;
  logic             i_rdata_ready;
  logic [WIDTH-1:0] o_rdata;
  logic             o_rdata_last;
  logic             o_mem_en;
  logic             o_mem_we;
  logic [ADDR-1:0]  o_mem_addr;
  logic [WIDTH-1:0] o_mem_din;
  logic [WIDTH-1:0] i_mem_dout;
  logic             o_busy;
  logic             o_done;

  // Controller side.
  modport slave (
    input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_len,
    input  i_wdata_valid, i_wdata, i_rdata_ready, i_mem_dout,
    output o_cmd_ready, o_wdata_ready, o_rdata_valid, o_rdata, o_rdata_last,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_din, o_busy, o_done
  );

  // Master / memory side.
  modport master (
    output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_len,
    output i_wdata_valid, i_wdata, i_rdata_ready, i_mem_dout,
    input  o_cmd_ready, o_wdata_ready, o_rdata_valid, o_rdata, o_rdata_last,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_din, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/mem_burst_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_port_ctrl
// Brief    : Read/write burst controller for one port of a dual-port memory
//            bank, with a 2-entry read response buffer.
// Revision : 1.0
// ============================================================================
module mem_burst_port_ctrl #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mem_burst_port_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ADDR-1:0]  r_cur_addr;
  logic [ADDR-1:0]  r_beats_left;
  logic             r_in_flight;
  logic             r_in_flight_last;
  logic [WIDTH-1:0] r_buf_data [2];
  logic [1:0]       r_buf_last;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             r_done;

  logic             w_cmd_ready;
  logic             w_cmd_hs;
  logic             w_wdata_ready;
  logic             w_wr_beat;
  logic             w_rvalid;
  logic             w_pop;
  logic             w_head_last;
  logic [2:0]       w_occ;
  logic [2:0]       w_lim;
  logic             w_rd_issue;
  logic             w_last_beat;
  logic             w_burst_end;

  assign w_cmd_ready   = !i_rst && (r_state == ST_IDLE);
  assign w_cmd_hs      = w_cmd_ready && bus.i_cmd_valid;
  assign w_wdata_ready = !i_rst && (r_state == ST_WRITE);
  assign w_wr_beat     = w_wdata_ready && bus.i_wdata_valid;
  assign w_rvalid      = !i_rst && (r_count != 2'd0);
  assign w_pop         = w_rvalid && bus.i_rdata_ready;
  assign w_head_last   = r_buf_last[r_rd_ptr];
  assign w_last_beat   = (r_beats_left == '0);

  // Only issue a read when its data is guaranteed a buffer slot on capture.
  assign w_occ      = {1'b0, r_count} + {2'b00, r_in_flight};
  assign w_lim      = 3'd2 + {2'b00, w_pop};
  assign w_rd_issue = !i_rst && (r_state == ST_READ) && (w_occ < w_lim);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_cmd_hs) w_state_nxt = bus.i_cmd_we ? ST_WRITE : ST_READ;
      ST_WRITE: if (w_wr_beat && w_last_beat) w_state_nxt = ST_IDLE;
      ST_READ:  if (w_rd_issue && w_last_beat) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pop && w_head_last && !r_in_flight) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_burst_end = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= ST_IDLE;
      r_cur_addr       <= '0;
      r_beats_left     <= '0;
      r_in_flight      <= 1'b0;
      r_in_flight_last <= 1'b0;
      r_buf_last       <= 2'b00;
      r_rd_ptr         <= 1'b0;
      r_wr_ptr         <= 1'b0;
      r_count          <= 2'd0;
      r_done           <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_burst_end;

      if (w_cmd_hs) begin
        r_cur_addr   <= bus.i_cmd_addr;
        r_beats_left <= bus.i_cmd_len;
      end else if (w_wr_beat || w_rd_issue) begin
        r_cur_addr   <= r_cur_addr + 1'b1;
        r_beats_left <= r_beats_left - 1'b1;
      end

      r_in_flight      <= w_rd_issue;
      r_in_flight_last <= w_rd_issue && w_last_beat;

      // Memory data is valid the cycle after issue; capture it then.
      if (r_in_flight) begin
        r_buf_data[r_wr_ptr] <= bus.i_mem_dout;
        r_buf_last[r_wr_ptr] <= r_in_flight_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_in_flight} - {1'b0, w_pop};
    end
  end

  assign bus.o_cmd_ready   = w_cmd_ready;
  assign bus.o_wdata_ready = w_wdata_ready;
  assign bus.o_rdata_valid = w_rvalid;
  assign bus.o_rdata       = w_rvalid ? r_buf_data[r_rd_ptr] : '0;
  assign bus.o_rdata_last  = w_rvalid && w_head_last;
  assign bus.o_mem_en      = w_wr_beat || w_rd_issue;
  assign bus.o_mem_we      = w_wr_beat;
  assign bus.o_mem_addr    = i_rst ? '0 : r_cur_addr;
  assign bus.o_mem_din     = bus.i_wdata;
  assign bus.o_busy        = !i_rst && (r_state != ST_IDLE);
  assign bus.o_done        = !i_rst && r_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_burst_port_ctrl
// Brief    : Scoreboard bench for mem_burst_port_ctrl against a bank model.
// Revision : 1.0
// ============================================================================
module tb_mem_burst_port_ctrl;
  localparam int WIDTH = 8;
  localparam int ADDR  = 3;
  localparam int DEPTH = 1 << ADDR;

  typedef struct packed { logic [WIDTH-1:0] data; logic last; } rd_t;
  typedef struct packed { logic [ADDR-1:0] addr; logic [WIDTH-1:0] data; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_burst_port_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

  mem_burst_port_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Synchronous-read memory bank behind the port.
  logic [WIDTH-1:0] bank [DEPTH];
  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) bank[bus.o_mem_addr] <= bus.o_mem_din;
      else              bus.i_mem_dout       <= bank[bus.o_mem_addr];
    end
  end

  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] wbuf [DEPTH];
  rd_t              exp_rd[$];
  wr_t              exp_wr[$];
  logic [ADDR-1:0]  exp_raddr[$];
  int               n_checks;
  int               n_errors;
  int               rdy_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor_step();
    rd_t e;
    wr_t w;
    logic [ADDR-1:0] a;
    if (!rst) begin
      if (bus.o_rdata_valid && bus.i_rdata_ready) begin
        if (exp_rd.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_rdata: got %0h with no beat expected", bus.o_rdata);
        end else begin
          e = exp_rd.pop_front();
          chk("rdata", bus.o_rdata, e.data);
          chk("rdata_last", bus.o_rdata_last, e.last);
        end
      end
      if (bus.o_mem_en && bus.o_mem_we) begin
        if (exp_wr.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_write: got addr %0h with no write expected", bus.o_mem_addr);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", bus.o_mem_addr, w.addr);
          chk("wr_data", bus.o_mem_din, w.data);
        end
      end
      if (bus.o_mem_en && !bus.o_mem_we) begin
        if (exp_raddr.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_read: got addr %0h with no read expected", bus.o_mem_addr);
        end else begin
          a = exp_raddr.pop_front();
          chk("rd_addr", bus.o_mem_addr, a);
        end
      end
    end
  endtask

  task automatic do_cmd(input logic we, input int addr, input int len);
    logic hs;
    hs = 1'b0;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = we;
    bus.i_cmd_addr  = ADDR'(addr);
    bus.i_cmd_len   = ADDR'(len);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      hs = bus.o_cmd_ready;
      @(posedge clk); #1;
      if (hs) break;
    end
    bus.i_cmd_valid = 1'b0;
    if (!hs) begin
      n_checks++; n_errors++;
      $display("FAIL cmd_timeout: got no o_cmd_ready required within 50 cycles");
    end
  endtask

  // gap: 0 = continuous, 1 = alternating 1,0,1,..., 2 = random
  task automatic write_burst(input int addr, input int len, input int gap, output int cycles);
    int k;
    int a;
    logic hs;
    bus.i_wdata_valid = 1'b0;
    for (int j = 0; j <= len; j++) begin
      a = (addr + j) % DEPTH;
      exp_wr.push_back('{addr: ADDR'(a), data: wbuf[j]});
      ref_mem[a] = wbuf[j];
    end
    do_cmd(1'b1, addr, len);
    k = 0;
    cycles = 0;
    while (k <= len && cycles < 200) begin
      case (gap)
        0:       bus.i_wdata_valid = 1'b1;
        1:       bus.i_wdata_valid = (cycles % 2 == 0);
        default: bus.i_wdata_valid = ($urandom_range(0, 3) != 0);
      endcase
      bus.i_wdata = bus.i_wdata_valid ? wbuf[k] : WIDTH'($urandom);
      @(negedge clk);
      hs = bus.i_wdata_valid && bus.o_wdata_ready;
      @(posedge clk); #1;
      cycles++;
      if (hs) k++;
    end
    bus.i_wdata_valid = 1'b0;
    if (k <= len) begin
      n_checks++; n_errors++;
      $display("FAIL wdata_timeout: got %0d beats required %0d", k, len + 1);
    end
  endtask

  task automatic read_burst(input int addr, input int len);
    int a;
    for (int j = 0; j <= len; j++) begin
      a = (addr + j) % DEPTH;
      exp_raddr.push_back(ADDR'(a));
      exp_rd.push_back('{data: ref_mem[a], last: (j == len)});
    end
    bus.i_wdata_valid = 1'($urandom_range(0, 1));
    do_cmd(1'b0, addr, len);
  endtask

  // exp_cyc = 0 skips the latency comparison.
  task automatic wait_done(input int exp_cyc);
    int got;
    got = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.o_done) begin got = i; break; end
    end
    if (got == 0) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout: got no o_done required within 300 cycles");
    end else begin
      chk("done_busy", bus.o_busy, 0);
      chk("done_cmd_ready", bus.o_cmd_ready, 1);
      if (exp_cyc > 0) chk("done_latency", got, exp_cyc);
    end
  endtask

  initial begin
    int cyc;
    int issues;
    int pops;
    logic have;
    logic [WIDTH-1:0] held;
    n_checks = 0;
    n_errors = 0;
    rdy_mode = 1;
    bus.i_cmd_valid   = 1'b0;
    bus.i_cmd_we      = 1'b0;
    bus.i_cmd_addr    = '0;
    bus.i_cmd_len     = '0;
    bus.i_wdata_valid = 1'b0;
    bus.i_wdata       = 8'h5A;
    bus.i_rdata_ready = 1'b1;

    fork
      forever begin
        @(posedge clk); #1;
        case (rdy_mode)
          0:       bus.i_rdata_ready = 1'b0;
          1:       bus.i_rdata_ready = 1'b1;
          default: bus.i_rdata_ready = ($urandom_range(0, 3) != 0);
        endcase
      end
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", bus.o_cmd_ready, 0);
    chk("rst_wdata_ready", bus.o_wdata_ready, 0);
    chk("rst_mem_en", bus.o_mem_en, 0);
    chk("rst_mem_we", bus.o_mem_we, 0);
    chk("rst_rdata_valid", bus.o_rdata_valid, 0);
    chk("rst_rdata_last", bus.o_rdata_last, 0);
    chk("rst_rdata", bus.o_rdata, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_mem_addr", bus.o_mem_addr, 0);
    chk("rst_mem_din", bus.o_mem_din, 8'h5A);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.o_cmd_ready, 1);

    // Fill the whole bank so every later read has a defined reference.
    for (int j = 0; j < DEPTH; j++) wbuf[j] = WIDTH'($urandom);
    write_burst(0, DEPTH - 1, 0, cyc);
    wait_done(1);

    // Basic write then read-back
    for (int j = 0; j < 4; j++) wbuf[j] = WIDTH'(8'hA1 + j);
    write_burst(2, 3, 0, cyc);
    chk("wr_continuous_cycles", cyc, 4);
    wait_done(1);
    read_burst(2, 3);
    wait_done(7);

    // Wrap-around
    for (int j = 0; j < 4; j++) wbuf[j] = WIDTH'($urandom);
    write_burst(6, 3, 0, cyc);
    wait_done(1);
    read_burst(6, 3);
    wait_done(7);

    // Single-beat read latency
    read_burst(0, 0);
    wait_done(4);

    // Back-pressure
    rdy_mode = 0;
    @(posedge clk); #2;
    read_burst(0, 7);
    issues = 0;
    have = 1'b0;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_mem_en) issues++;
      if (bus.o_rdata_valid) begin
        if (!have) begin held = bus.o_rdata; have = 1'b1; end
        else chk("bp_rdata_stable", bus.o_rdata, held);
      end
    end
    chk("bp_issues", issues, 2);
    chk("bp_valid_held", bus.o_rdata_valid, 1);
    rdy_mode = 1;
    @(posedge clk); #2;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.o_rdata_valid && bus.i_rdata_ready) pops++;
    end
    chk("bp_pop_rate", pops, 8);
    wait_done(1);

    // Gapped write data
    for (int j = 0; j < 3; j++) wbuf[j] = WIDTH'($urandom);
    write_burst(3, 2, 1, cyc);
    chk("wr_gap_cycles", cyc, 5);
    wait_done(1);

    // Reset in the middle of a read burst
    read_burst(0, 3);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_en", bus.o_mem_en, 0);
    chk("midrst_rdata_valid", bus.o_rdata_valid, 0);
    chk("midrst_cmd_ready", bus.o_cmd_ready, 0);
    chk("midrst_busy", bus.o_busy, 0);
    chk("midrst_mem_addr", bus.o_mem_addr, 0);
    exp_rd.delete();
    exp_raddr.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_wdata_valid = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready_after", bus.o_cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_stale_valid", bus.o_rdata_valid, 0);
      chk("midrst_no_access", bus.o_mem_en, 0);
      @(negedge clk);
    end
    read_burst(2, 3);
    wait_done(7);

    // Randomized bursts with random back-pressure and write gaps
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      int ra;
      int rl;
      ra = $urandom_range(0, DEPTH - 1);
      rl = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j <= rl; j++) wbuf[j] = WIDTH'($urandom);
        write_burst(ra, rl, 2, cyc);
        wait_done(1);
      end else begin
        read_burst(ra, rl);
        wait_done(0);
      end
    end

    rdy_mode = 1;
    repeat (4) @(negedge clk);
    chk("leftover_rd", exp_rd.size(), 0);
    chk("leftover_wr", exp_wr.size(), 0);
    chk("leftover_raddr", exp_raddr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
